bp_clint_slice: RTL and testbench
=================================

Name: bp_clint_slice

Overview:
- Memory-mapped core-local interruptor (CLINT) device that serves the clint_dev_gp window at 0x0030_0000 of the device address map.
- Sits directly downstream of the address decoder that steers uncached device requests by address.
- Holds the per-core msip bits, the per-core mtimecmp registers and the shared mtime counter.
- Drives the software and timer interrupt lines into each core's CSR file.

Parameters:
- num_core_p, 1, number of cores served; must be 1..16.
- addr_width_p, 40, request physical address width.
- data_width_p, 64, request and response data width.

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- rtc_tick_i  in  1  one-cycle strobe that advances mtime; already synchronous to clk_i.
- in_v_i  in  1  request valid.
- in_ready_o  out  1  request ready.
- in_we_i  in  1  1 = store, 0 = load.
- in_addr_i  in  addr_width_p  physical address.
- in_size_i  in  2  access size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B.
- in_data_i  in  data_width_p  store data, LSB-aligned.
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed.
- resp_data_o  out  data_width_p  load data, LSB-aligned; 0 for stores.
- resp_err_o  out  1  unmapped address or illegal size.
- software_irq_o  out  num_core_p  msip[i].
- timer_irq_o  out  num_core_p  registered (mtime >= mtimecmp[i]).

Behaviour:
- Register map (offset = in_addr_i[19:0] relative to the window base):
  - msip[i] at 0x0000 + 4*i; 32-bit register, bit 0 only, other bits read as 0.
  - mtimecmp[i] at 0x4000 + 8*i; 64-bit register.
  - mtime at 0xBFF8; 64-bit register.
  - Any other offset, or an index >= num_core_p, is unmapped.
- Legal sizes:
  - msip: 4B only.
  - mtimecmp and mtime: 4B or 8B, naturally aligned.
  - A 4B access to a 64-bit register uses addr[2] to select the half (0 = low, 1 = high).
  - Any other size or misalignment is illegal.
- FSM has two states, IDLE and RESP:
  - in_ready_o is 1 only in IDLE; a request is accepted on in_v_i & in_ready_o.
  - On accept: capture the response, apply the store in the same edge, go to RESP.
  - In RESP: resp_v_o = 1 and the response holds stable until resp_yumi_i; then return to IDLE.
  - One outstanding request at most; accept-to-resp_v latency is 1 cycle; throughput is 1 request per 2 cycles.
  - resp_yumi_i while not in RESP is ignored.
- Load data is sampled at the accept edge, before any same-cycle tick takes effect. A 4B load returns zero-extended data.
- Error handling: load returns 0 with resp_err_o = 1; store has no side effect and resp_err_o = 1. The error is still a normal 1-cycle response.
- mtime:
  - Increments by 1 on each rtc_tick_i and wraps from all-ones to 0.
  - A store to mtime in the same cycle as a tick takes priority: the stored value lands and the tick is dropped.
  - A 4B store replaces only the addressed half.
- timer_irq_o[i] is the registered compare of the current mtime and mtimecmp[i]. It updates the cycle after either value changes. It is level-sensitive and clears only when mtimecmp is raised above mtime or mtime wraps.
- software_irq_o[i] equals the msip[i] register directly.
- Reset, asynchronous on reset_n_i low, applies immediately:
  - mtime = 0; mtimecmp[i] = all-ones; msip = 0; state = IDLE.
  - resp_v_o = 0; resp_data_o = 0; resp_err_o = 0; in_ready_o = 0 while asserted, then 1.
  - timer_irq_o = 0; software_irq_o = 0.
  - A request in flight is dropped with no response; the requester must also be reset.

Decomposition:
- Shared package (bp_common_pkg) holds:
  - the register offsets (mipi, mtimecmp, mtime offsets relative to clint_dev_base_addr_gp);
  - the 2-bit size enum;
  - a bp_clint_req_s struct {we, addr, size, data}.
- One natural sub-module, bp_clint_decode: combinational offset/size to {register select, core index, half, err}. It keeps the FSM and register file in the top level.

Test Plan:
- Reset, then 8B load from 0x30_BFF8 after 5 ticks -> data 5, err 0. 8B load of mtimecmp[0] -> 0xFFFF_FFFF_FFFF_FFFF.
- 4B store 1 to 0x30_0000 -> software_irq_o[0] rises the cycle after accept. Store 0 -> it falls.
- 8B store mtimecmp[0] = 10; tick 10 times -> timer_irq_o[0] = 0 after 9 ticks and 1 the cycle after the 10th. Store mtimecmp = 20 -> it deasserts.
- 8B store mtime = 0xFFFF_FFFF_FFFF_FFFF, then one tick -> load returns 0. A store to mtime = 7 in the same cycle as a tick -> load returns 7.
- 4B store 0xAAAA_5555 to 0x30_4004 -> mtimecmp[0] high half = 0xAAAA_5555, low half = 0xFFFF_FFFF.
- Error and back-pressure cases:
  - Load from 0x30_8000 -> data 0, err 1.
  - 2B store to msip -> err 1, msip unchanged.
  - resp_yumi_i held low 4 cycles -> response stable and in_ready_o stays 0.
  - reset_n_i pulsed in RESP -> resp_v_o drops immediately.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared CLINT definitions: register offsets, access size encoding,
// request bundle and the 64-bit half-word helpers.
package bp_common_pkg;

  localparam int clint_addr_width_gp = 40;
  localparam int clint_data_width_gp = 64;

  localparam logic [39:0] clint_dev_base_addr_gp   = 40'h00_0030_0000;
  localparam logic [19:0] clint_mipi_offset_gp     = 20'h0_0000;
  localparam logic [19:0] clint_mtimecmp_offset_gp = 20'h0_4000;
  localparam logic [19:0] clint_mtime_offset_gp    = 20'h0_BFF8;

  typedef enum logic [1:0] {
    e_size_1b = 2'b00,
    e_size_2b = 2'b01,
    e_size_4b = 2'b10,
    e_size_8b = 2'b11
  } bp_clint_size_e;

  typedef enum logic [1:0] {
    e_sel_none     = 2'b00,
    e_sel_msip     = 2'b01,
    e_sel_mtimecmp = 2'b10,
    e_sel_mtime    = 2'b11
  } bp_clint_sel_e;

  typedef struct packed {
    logic                           we;
    logic [clint_addr_width_gp-1:0] addr;
    bp_clint_size_e                 size;
    logic [clint_data_width_gp-1:0] data;
  } bp_clint_req_s;

  // New value of a 64-bit register after an 8B store or a 4B store to one half.
  function automatic logic [63:0] clint_merge64(input logic [63:0] old_val,
                                                input logic [63:0] wr_data,
                                                input logic        is_8b,
                                                input logic        hi);
    logic [63:0] v;
    if (is_8b) begin
      v = wr_data;
    end else if (hi) begin
      v = {wr_data[31:0], old_val[31:0]};
    end else begin
      v = {old_val[63:32], wr_data[31:0]};
    end
    return v;
  endfunction

  // Load view of a 64-bit register: whole value, or one zero-extended half.
  function automatic logic [63:0] clint_read64(input logic [63:0] val,
                                               input logic        is_8b,
                                               input logic        hi);
    logic [63:0] v;
    if (is_8b) begin
      v = val;
    end else if (hi) begin
      v = {32'h0000_0000, val[63:32]};
    end else begin
      v = {32'h0000_0000, val[31:0]};
    end
    return v;
  endfunction

endpackage

// File: rtl/bp_clint_slice_decode.sv
// Combinational CLINT offset/size decode: picks the register, the core
// index and the 32-bit half, and flags unmapped or illegal accesses.
module bp_clint_decode
  import bp_common_pkg::*;
#(
  parameter int num_core_p = 1
) (
  input  logic [19:0]    i_offset,
  input  bp_clint_size_e i_size,
  output bp_clint_sel_e  o_sel,
  output logic [3:0]     o_idx,
  output logic           o_hi,
  output logic           o_is_8b,
  output logic           o_err
);

  localparam logic [11:0] num_core_lp = 12'(num_core_p);

  bp_clint_sel_e w_sel;
  logic          w_in_range;
  logic          w_size_ok;
  logic [3:0]    w_idx;
  logic          w_size64_ok;

  // 64-bit registers take 8B naturally aligned or 4B word aligned accesses.
  assign w_size64_ok = ((i_size == e_size_8b) && (i_offset[2:0] == 3'b000))
                    || ((i_size == e_size_4b) && (i_offset[1:0] == 2'b00));

  // Region select, index range and size legality.
  always_comb begin
    w_sel      = e_sel_none;
    w_in_range = 1'b0;
    w_size_ok  = 1'b0;
    w_idx      = 4'h0;
    if (i_offset[19:14] == clint_mipi_offset_gp[19:14]) begin
      w_sel      = e_sel_msip;
      w_in_range = (i_offset[13:2] < num_core_lp) && (i_offset[1:0] == 2'b00);
      w_size_ok  = (i_size == e_size_4b);
      w_idx      = i_offset[5:2];
    end else if (i_offset[19:14] == clint_mtimecmp_offset_gp[19:14]) begin
      w_sel      = e_sel_mtimecmp;
      w_in_range = ({1'b0, i_offset[13:3]} < num_core_lp);
      w_size_ok  = w_size64_ok;
      w_idx      = i_offset[6:3];
    end else if (i_offset[19:3] == clint_mtime_offset_gp[19:3]) begin
      w_sel      = e_sel_mtime;
      w_in_range = 1'b1;
      w_size_ok  = w_size64_ok;
      w_idx      = 4'h0;
    end else begin
      w_sel      = e_sel_none;
    end
  end

  assign o_err   = ~((w_sel != e_sel_none) && w_in_range && w_size_ok);
  assign o_sel   = o_err ? e_sel_none : w_sel;
  assign o_idx   = w_idx;
  assign o_hi    = i_offset[2];
  assign o_is_8b = (i_size == e_size_8b);

endmodule

// File: rtl/bp_clint_slice.sv
// CLINT device: msip, mtimecmp and mtime registers behind a one-deep
// request/response port, driving software and timer interrupts per core.
module bp_clint_slice
  import bp_common_pkg::*;
#(
  parameter int num_core_p   = 1,
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    rtc_tick_i,
  input  logic                    in_v_i,
  output logic                    in_ready_o,
  input  logic                    in_we_i,
  input  logic [addr_width_p-1:0] in_addr_i,
  input  logic [1:0]              in_size_i,
  input  logic [data_width_p-1:0] in_data_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic                    resp_err_o,
  output logic [num_core_p-1:0]   software_irq_o,
  output logic [num_core_p-1:0]   timer_irq_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  bp_clint_req_s  w_req;
  bp_clint_sel_e  w_sel;
  logic [3:0]     w_idx;
  logic           w_hi;
  logic           w_is_8b;
  logic           w_err;
  logic           w_accept;
  logic           w_yumi;
  logic           w_store;
  logic [63:0]    w_cmp_sel;
  logic [63:0]    w_rd_data;
  logic           w_unused_addr;

  logic [0:0]      r_state;
  logic            r_ready;
  logic            r_resp_v;
  logic [63:0]     r_resp_data;
  logic            r_resp_err;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp [num_core_p];
  logic [num_core_p-1:0] r_msip;
  logic [num_core_p-1:0] r_timer_irq;

  assign w_req.we   = in_we_i;
  assign w_req.addr = clint_addr_width_gp'(in_addr_i);
  assign w_req.size = bp_clint_size_e'(in_size_i);
  assign w_req.data = clint_data_width_gp'(in_data_i);

  // The upstream decoder already steered by the window; only the offset matters.
  assign w_unused_addr = ^(w_req.addr[39:20] ^ clint_dev_base_addr_gp[39:20]);

  bp_clint_decode #(
    .num_core_p(num_core_p)
  ) u_decode (
    .i_offset(w_req.addr[19:0]),
    .i_size  (w_req.size),
    .o_sel   (w_sel),
    .o_idx   (w_idx),
    .o_hi    (w_hi),
    .o_is_8b (w_is_8b),
    .o_err   (w_err)
  );

  assign w_accept = in_v_i & r_ready;
  assign w_yumi   = (r_state == RESP) & resp_yumi_i;
  assign w_store  = w_accept & w_req.we & ~w_err;

  // Load data mux over the current (pre-edge) register values.
  always_comb begin
    w_cmp_sel = 64'hFFFF_FFFF_FFFF_FFFF;
    w_rd_data = 64'h0;
    for (int i = 0; i < num_core_p; i++) begin
      w_cmp_sel = (w_idx == 4'(i)) ? r_mtimecmp[i] : w_cmp_sel;
    end
    case (w_sel)
      e_sel_msip: begin
        for (int i = 0; i < num_core_p; i++) begin
          w_rd_data = (w_idx == 4'(i)) ? {63'h0, r_msip[i]} : w_rd_data;
        end
      end
      e_sel_mtimecmp: w_rd_data = clint_read64(w_cmp_sel, w_is_8b, w_hi);
      e_sel_mtime:    w_rd_data = clint_read64(r_mtime, w_is_8b, w_hi);
      default:        w_rd_data = 64'h0;
    endcase
  end

  // Two-state request FSM; ready is low during reset and while a response waits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else if (w_accept) begin
      r_state <= RESP;
      r_ready <= 1'b0;
    end else if (w_yumi) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
    end else begin
      r_ready <= (r_state == IDLE);
    end
  end

  // Response capture at accept, held until consumed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_resp_v    <= 1'b0;
      r_resp_data <= 64'h0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_v    <= 1'b1;
      r_resp_data <= w_req.we ? 64'h0 : w_rd_data;
      r_resp_err  <= w_err;
    end else if (w_yumi) begin
      r_resp_v    <= 1'b0;
      r_resp_data <= 64'h0;
      r_resp_err  <= 1'b0;
    end
  end

  // mtime: a store wins over a same-cycle tick; ticks wrap naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mtime <= 64'h0;
    end else if (w_store && (w_sel == e_sel_mtime)) begin
      r_mtime <= clint_merge64(r_mtime, w_req.data, w_is_8b, w_hi);
    end else if (rtc_tick_i) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Per-core mtimecmp and msip stores.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_core_p; i++) begin
        r_mtimecmp[i] <= 64'hFFFF_FFFF_FFFF_FFFF;
        r_msip[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (w_store && (w_sel == e_sel_mtimecmp) && (w_idx == 4'(i))) begin
          r_mtimecmp[i] <= clint_merge64(r_mtimecmp[i], w_req.data, w_is_8b, w_hi);
        end
        if (w_store && (w_sel == e_sel_msip) && (w_idx == 4'(i))) begin
          r_msip[i] <= w_req.data[0];
        end
      end
    end
  end

  // Registered timer compare; follows mtime/mtimecmp one cycle later.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_timer_irq <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        r_timer_irq[i] <= (r_mtime >= r_mtimecmp[i]);
      end
    end
  end

  assign in_ready_o     = r_ready;
  assign resp_v_o       = r_resp_v;
  assign resp_data_o    = data_width_p'(r_resp_data);
  assign resp_err_o     = r_resp_err;
  assign software_irq_o = r_msip;
  assign timer_irq_o    = r_timer_irq;

endmodule

// File: tb/tb_bp_clint_slice.sv
// Directed bench for bp_clint_slice: one core, hand-computed expectations.
module tb_bp_clint_slice;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rtc_tick = 1'b0;
  logic        in_v = 1'b0;
  logic        in_ready;
  logic        in_we = 1'b0;
  logic [39:0] in_addr = 40'h0;
  logic [1:0]  in_size = 2'b00;
  logic [63:0] in_data = 64'h0;
  logic        resp_v;
  logic        resp_yumi = 1'b0;
  logic [63:0] resp_data;
  logic        resp_err;
  logic [0:0]  sw_irq;
  logic [0:0]  tm_irq;

  int total = 0;
  int bad   = 0;

  logic [63:0] rd;
  logic        er;

  bp_clint_slice #(
    .num_core_p  (1),
    .addr_width_p(40),
    .data_width_p(64)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .rtc_tick_i    (rtc_tick),
    .in_v_i        (in_v),
    .in_ready_o    (in_ready),
    .in_we_i       (in_we),
    .in_addr_i     (in_addr),
    .in_size_i     (in_size),
    .in_data_i     (in_data),
    .resp_v_o      (resp_v),
    .resp_yumi_i   (resp_yumi),
    .resp_data_o   (resp_data),
    .resp_err_o    (resp_err),
    .software_irq_o(sw_irq),
    .timer_irq_o   (tm_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge with the port idle.
  task automatic do_req(input logic we, input logic [39:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic tick,
                        output logic [63:0] rdata, output logic rerr);
    int n;
    n = 0;
    in_v = 1'b1; in_we = we; in_addr = addr; in_size = size; in_data = data;
    rtc_tick = tick;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("req_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_v = 1'b0; rtc_tick = 1'b0;
    check_eq("resp_v_latency", 64'(resp_v), 64'd1);
    rdata = resp_data;
    rerr  = resp_err;
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      rtc_tick = 1'b1;
      @(negedge clk);
    end
    rtc_tick = 1'b0;
  endtask

  initial begin
    // reset state
    #1 reset_n = 1'b0;
    #3;
    check_eq("rst_ready", 64'(in_ready), 64'd0);
    check_eq("rst_resp_v", 64'(resp_v), 64'd0);
    check_eq("rst_resp_data", resp_data, 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    check_eq("rst_sw_irq", 64'(sw_irq), 64'd0);
    check_eq("rst_tm_irq", 64'(tm_irq), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(in_ready), 64'd1);

    // mtime counts ticks; mtimecmp resets to all-ones
    do_tick(5);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("mtime_5", rd, 64'd5);
    check_eq("mtime_5_err", 64'(er), 64'd0);
    do_req(1'b0, 40'h30_4000, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("mtimecmp_rst", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // msip set/clear
    check_eq("sw_irq_before", 64'(sw_irq), 64'd0);
    do_req(1'b1, 40'h30_0000, 2'd2, 64'h1, 1'b0, rd, er);
    check_eq("sw_irq_set", 64'(sw_irq), 64'd1);
    check_eq("store_resp_data", rd, 64'd0);
    check_eq("store_resp_err", 64'(er), 64'd0);
    do_req(1'b0, 40'h30_0000, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("msip_load", rd, 64'd1);
    do_req(1'b1, 40'h30_0000, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("sw_irq_clr", 64'(sw_irq), 64'd0);

    // timer compare
    do_req(1'b1, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    do_req(1'b1, 40'h30_4000, 2'd3, 64'd10, 1'b0, rd, er);
    do_tick(9);
    @(negedge clk);
    check_eq("tm_irq_9", 64'(tm_irq), 64'd0);
    do_tick(1);
    check_eq("tm_irq_10_same", 64'(tm_irq), 64'd0);
    @(negedge clk);
    check_eq("tm_irq_10_next", 64'(tm_irq), 64'd1);
    do_req(1'b1, 40'h30_4000, 2'd3, 64'd20, 1'b0, rd, er);
    check_eq("tm_irq_raise_cmp", 64'(tm_irq), 64'd0);

    // wrap and store-vs-tick priority
    do_req(1'b1, 40'h30_BFF8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er);
    do_tick(1);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("mtime_wrap", rd, 64'd0);
    do_req(1'b1, 40'h30_BFF8, 2'd3, 64'd7, 1'b1, rd, er);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("mtime_store_wins", rd, 64'd7);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b1, rd, er);
    check_eq("load_before_tick", rd, 64'd7);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("load_after_tick", rd, 64'd8);

    // 4B half store
    do_req(1'b1, 40'h30_4000, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er);
    do_req(1'b1, 40'h30_4004, 2'd2, 64'h0000_0000_AAAA_5555, 1'b0, rd, er);
    do_req(1'b0, 40'h30_4000, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("cmp_half_8b", rd, 64'hAAAA_5555_FFFF_FFFF);
    do_req(1'b0, 40'h30_4004, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("cmp_hi_4b", rd, 64'h0000_0000_AAAA_5555);
    do_req(1'b0, 40'h30_4000, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("cmp_lo_4b", rd, 64'h0000_0000_FFFF_FFFF);

    // errors
    do_req(1'b0, 40'h30_8000, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("unmapped_data", rd, 64'd0);
    check_eq("unmapped_err", 64'(er), 64'd1);
    do_req(1'b1, 40'h30_0000, 2'd1, 64'h1, 1'b0, rd, er);
    check_eq("msip_2b_err", 64'(er), 64'd1);
    check_eq("msip_2b_noeffect", 64'(sw_irq), 64'd0);
    do_req(1'b0, 40'h30_0004, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("msip_idx1_err", 64'(er), 64'd1);
    do_req(1'b0, 40'h30_BFFC, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("mtime_misalign_err", 64'(er), 64'd1);
    check_eq("mtime_misalign_data", rd, 64'd0);
    do_req(1'b0, 40'h30_BFFC, 2'd2, 64'h0, 1'b0, rd, er);
    check_eq("mtime_hi_err", 64'(er), 64'd0);
    check_eq("mtime_hi_data", rd, 64'd0);
    do_req(1'b0, 40'h30_BFF8, 2'd0, 64'h0, 1'b0, rd, er);
    check_eq("mtime_1b_err", 64'(er), 64'd1);

    // back-pressure: response holds while yumi is low
    in_v = 1'b1; in_we = 1'b0; in_addr = 40'h30_4000; in_size = 2'd3;
    @(negedge clk);
    in_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_resp_v", 64'(resp_v), 64'd1);
      check_eq("bp_resp_data", resp_data, 64'hAAAA_5555_FFFF_FFFF);
      check_eq("bp_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
    check_eq("bp_resp_v_done", 64'(resp_v), 64'd0);
    check_eq("bp_ready_back", 64'(in_ready), 64'd1);

    // reset while a response is pending
    do_req(1'b1, 40'h30_0000, 2'd2, 64'h1, 1'b0, rd, er);
    in_v = 1'b1; in_we = 1'b0; in_addr = 40'h30_BFF8; in_size = 2'd3;
    @(negedge clk);
    in_v = 1'b0;
    check_eq("pre_rst_resp_v", 64'(resp_v), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_resp_v_drop", 64'(resp_v), 64'd0);
    check_eq("rst_ready_low", 64'(in_ready), 64'd0);
    check_eq("rst_sw_clear", 64'(sw_irq), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 40'h30_4000, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("post_rst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 40'h30_BFF8, 2'd3, 64'h0, 1'b0, rd, er);
    check_eq("post_rst_mtime", rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
